// File: rtl/down_timer_if.sv
// Control and status bundle between the CPU-side register block (master)
// and the down_timer expiry stage (slave).
interface down_timer_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             periodic;
    logic             tick_en;
    logic             irq_ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             borrow;
    logic             irq;
    logic             ovf;

    modport master (
        output load, load_val, start, stop, periodic, tick_en, irq_ack,
        input  count, busy, borrow, irq, ovf
    );

    modport slave (
        input  load, load_val, start, stop, periodic, tick_en, irq_ack,
        output count, busy, borrow, irq, ovf
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer driven by prescaler carry pulses; pulses
// borrow on expiry and raises sticky irq/ovf flags, one-shot or auto-reload.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | stopped or never started; count held, ticks ignored
//  RUN   | counting tick_en pulses down toward expiry
//  DONE  | one-shot expired with count 0; waits for start or load
module down_timer #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    down_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] reload, reload_nxt;
    logic [WIDTH-1:0] count_r, count_nxt;
    logic             expire;
    logic             borrow_r, irq_r, ovf_r, busy_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            reload   <= '0;
            count_r  <= '0;
            borrow_r <= 1'b0;
            irq_r    <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            reload   <= reload_nxt;
            count_r  <= count_nxt;
            borrow_r <= expire;
            busy_r   <= (state_nxt == RUN);
            // A set from expiry outranks the ack; ovf only notes an unacked repeat.
            irq_r    <= expire | (irq_r & ~bus.irq_ack);
            ovf_r    <= ~bus.irq_ack & (ovf_r | (expire & irq_r));
        end
    end

    always_comb begin
        state_nxt  = state;
        reload_nxt = reload;
        count_nxt  = count_r;
        expire     = 1'b0;
        if (bus.load) begin
            reload_nxt = bus.load_val;
            count_nxt  = bus.load_val;
            if (state == DONE) state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    // stop has no effect here, so a concurrent start still acts
                    if (bus.start) begin
                        if (count_r != '0) begin
                            state_nxt = RUN;
                        end else if (reload != '0) begin
                            count_nxt = reload;
                            state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_nxt = IDLE;
                    end else if (bus.tick_en && count_r != '0) begin
                        if (count_r == WIDTH'(1)) begin
                            expire = 1'b1;
                            if (bus.periodic) begin
                                count_nxt = reload;
                            end else begin
                                count_nxt = '0;
                                state_nxt = DONE;
                            end
                        end else begin
                            count_nxt = count_r - WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.start && reload != '0) begin
                        count_nxt = reload;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.count  = count_r;
    assign bus.busy   = busy_r;
    assign bus.borrow = borrow_r;
    assign bus.irq    = irq_r;
    assign bus.ovf    = ovf_r;
endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: directed scenarios plus random traffic, all checked
// every cycle against an event-level model of the timer.
module tb_down_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    down_timer_if #(.WIDTH(8)) bus();
    down_timer #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Reference: "running" and "expired" flags instead of a state machine.
    int m_count  = 0;
    int m_reload = 0;
    bit m_running = 0, m_expired = 0;
    bit m_irq = 0, m_ovf = 0, m_borrow = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit hit;
        hit = 1'b0;
        if (rst) begin
            m_count = 0; m_reload = 0; m_running = 0; m_expired = 0;
            m_irq = 0; m_ovf = 0;
        end else begin
            if (bus.load) begin
                m_reload = bus.load_val;
                m_count  = bus.load_val;
                m_expired = 0;
            end else if (bus.stop && m_running) begin
                m_running = 0;
            end else if (bus.start && !m_running) begin
                if (!m_expired && m_count > 0) begin
                    m_running = 1;
                end else if (m_reload > 0) begin
                    m_count = m_reload;
                    m_running = 1;
                    m_expired = 0;
                end
            end else if (bus.tick_en && m_running && m_count > 0) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    hit = 1'b1;
                    if (bus.periodic) m_count = m_reload;
                    else begin
                        m_running = 0;
                        m_expired = 1;
                    end
                end
            end
            if (bus.irq_ack) m_ovf = 0;
            else if (hit && m_irq) m_ovf = 1;
            m_irq = hit || (m_irq && !bus.irq_ack);
        end
        m_borrow = hit;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("count",  bus.count,  m_count);
            chk("busy",   bus.busy,   m_running);
            chk("borrow", bus.borrow, m_borrow);
            chk("irq",    bus.irq,    m_irq);
            chk("ovf",    bus.ovf,    m_ovf);
        end
    end

    // Apply one cycle of inputs at a negedge and return at the next negedge.
    task automatic cyc(input bit r, input bit ld, input int lv, input bit st,
                       input bit sp, input bit per, input bit tk, input bit ack);
        rst = r; bus.load = ld; bus.load_val = 8'(lv); bus.start = st;
        bus.stop = sp; bus.periodic = per; bus.tick_en = tk; bus.irq_ack = ack;
        @(negedge clk);
    endtask

    task automatic idle_c(input bit per);
        cyc(0, 0, 0, 0, 0, per, 0, 0);
    endtask

    task automatic tick_c(input bit per);
        cyc(0, 0, 0, 0, 0, per, 1, 0);
    endtask

    initial begin
        bus.load = 0; bus.load_val = 0; bus.start = 0; bus.stop = 0;
        bus.periodic = 0; bus.tick_en = 0; bus.irq_ack = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk_on = 1'b1;
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);

        // one-shot of 3
        cyc(0, 1, 3, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("os_busy", bus.busy, 1);
        tick_c(0); tick_c(0);
        chk("os_borrow_early", bus.borrow, 0);
        tick_c(0);
        chk("os_borrow", bus.borrow, 1);
        chk("os_count", bus.count, 0);
        chk("os_irq", bus.irq, 1);
        chk("os_busy_done", bus.busy, 0);
        idle_c(0);
        chk("os_borrow_1cyc", bus.borrow, 0);

        // periodic reload 2, tick every 4th cycle, no ack
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick_c(1); idle_c(1); idle_c(1); idle_c(1);
        end
        chk("per_ovf", bus.ovf, 1);
        chk("per_count", bus.count, 2);
        chk("per_busy", bus.busy, 1);

        // stop / resume
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 5, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        tick_c(0); tick_c(0);
        chk("sr_count3", bus.count, 3);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick_c(0);
        chk("sr_held", bus.count, 3);
        chk("sr_idle", bus.busy, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        tick_c(0); tick_c(0); tick_c(0);
        chk("sr_borrow", bus.borrow, 1);
        chk("sr_count0", bus.count, 0);

        // simultaneous events
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        tick_c(0);
        cyc(0, 1, 7, 1, 0, 0, 1, 0);
        chk("sim_load7", bus.count, 7);
        chk("sim_run", bus.busy, 1);
        cyc(0, 1, 1, 0, 0, 1, 0, 0);
        tick_c(1);
        chk("sim_irq_first", bus.irq, 1);
        cyc(0, 0, 0, 0, 0, 1, 1, 1);
        chk("sim_irq_ack", bus.irq, 1);
        chk("sim_ovf_ack", bus.ovf, 0);

        // zero reload
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("zero_busy", bus.busy, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("zero_busy2", bus.busy, 0);

        // reset mid-run
        cyc(0, 1, 255, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick_c(0);
        chk("mr_count", bus.count, 245);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        chk("mr_count0", bus.count, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_irq", bus.irq, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, ld, st, sp, per, tk, ack;
            int lv;
            r   = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 19) == 0);
            lv  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 5));
            st  = ($urandom_range(0, 7) == 0);
            sp  = ($urandom_range(0, 24) == 0);
            per = $urandom_range(0, 1) != 0;
            tk  = $urandom_range(0, 1) != 0;
            ack = ($urandom_range(0, 9) == 0);
            cyc(r, ld, lv, st, sp, per, tk, ack);
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
